// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 host definitions: command codes, transmitter FSM encoding
// and the odd-parity rule used on the wire.
package ps2_host_tx_pkg;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] RSP_ACK      = 8'hFA;

    // Falls counted in a frame: 8 data, parity, stop, ack.
    localparam logic [3:0] BIT_CNT_MAX  = 4'd11;

    // DONE and ERR are the one-cycle pulse states before returning to IDLE.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_SHIFT,
        ST_RELEASE,
        ST_DONE,
        ST_ERR
    } tx_state_e;

    function automatic logic odd_parity(input logic [7:0] i_data);
        return ~^i_data;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for an asynchronous PS/2 pin plus a falling-edge
// strobe; shared by the host-transmit and keyboard-receive paths.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pin,
    output logic o_level,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Idle PS/2 lines float high, so reset to 1 to avoid a false fall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_fall  = r_prev & ~r_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift out
// start/data/parity/stop on device clock falls, then check the device ack.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       SCL,
    input  logic       SDA,
    output logic       scl_low,
    output logic       sda_low,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [INH_W-1:0] INH_SDA  = INH_W'(INHIBIT_CYCLES - 2);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    tx_state_e        r_state;
    logic [7:0]       r_data;
    logic             r_parity;
    logic [INH_W-1:0] r_inh_cnt;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic [3:0]       r_bit_cnt;
    logic             r_sda_low;

    tx_state_e        w_state_nxt;
    logic [7:0]       w_data_nxt;
    logic             w_parity_nxt;
    logic [INH_W-1:0] w_inh_nxt;
    logic [TMO_W-1:0] w_tmo_nxt;
    logic [3:0]       w_bit_nxt;
    logic             w_sda_nxt;

    logic             w_scl_level;
    logic             w_scl_fall;
    logic             w_sda_level;
    logic             w_sda_fall_unused;

    ps2_sync_edge u_scl_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_pin   (SCL),
        .o_level (w_scl_level),
        .o_fall  (w_scl_fall)
    );

    ps2_sync_edge u_sda_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_pin   (SDA),
        .o_level (w_sda_level),
        .o_fall  (w_sda_fall_unused)
    );

    // NOTE: every register is reset, including the data latch, so a mid-frame
    // reset can never leave a stale byte or counter behind.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_data    <= '0;
            r_parity  <= 1'b0;
            r_inh_cnt <= '0;
            r_tmo_cnt <= '0;
            r_bit_cnt <= '0;
            r_sda_low <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_data    <= w_data_nxt;
            r_parity  <= w_parity_nxt;
            r_inh_cnt <= w_inh_nxt;
            r_tmo_cnt <= w_tmo_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_sda_low <= w_sda_nxt;
        end
    end

    // NOTE: hold-current defaults come first so no path through the case
    // leaves a signal unassigned and infers a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_data_nxt   = r_data;
        w_parity_nxt = r_parity;
        w_inh_nxt    = r_inh_cnt;
        w_tmo_nxt    = r_tmo_cnt;
        w_bit_nxt    = r_bit_cnt;
        w_sda_nxt    = r_sda_low;

        case (r_state)
            ST_IDLE: begin
                w_sda_nxt = 1'b0;
                if (tx_valid && tx_ready) begin
                    w_state_nxt  = ST_INHIBIT;
                    w_data_nxt   = tx_data;
                    w_parity_nxt = odd_parity(tx_data);
                    w_inh_nxt    = '0;
                    w_tmo_nxt    = '0;
                    w_bit_nxt    = '0;
                end
            end
            ST_INHIBIT: begin
                w_inh_nxt = r_inh_cnt + 1'b1;
                if (r_inh_cnt == INH_SDA) w_sda_nxt = 1'b1;
                if (r_inh_cnt == INH_LAST) begin
                    w_state_nxt = ST_REQ;
                    w_tmo_nxt   = '0;
                    w_sda_nxt   = 1'b1;
                end
            end
            ST_REQ: begin
                w_tmo_nxt = r_tmo_cnt + 1'b1;
                if (w_scl_fall) begin
                    w_state_nxt = ST_SHIFT;
                    w_bit_nxt   = 4'd1;
                    w_sda_nxt   = ~r_data[0];
                end
            end
            ST_SHIFT: begin
                w_tmo_nxt = r_tmo_cnt + 1'b1;
                if (w_scl_fall) begin
                    w_bit_nxt = (r_bit_cnt == BIT_CNT_MAX) ? r_bit_cnt : r_bit_cnt + 4'd1;
                    // r_bit_cnt is the number of falls already seen before this one.
                    if (r_bit_cnt <= 4'd7) begin
                        w_sda_nxt = ~r_data[r_bit_cnt[2:0]];
                    end else if (r_bit_cnt == 4'd8) begin
                        w_sda_nxt = ~r_parity;
                    end else begin
                        w_sda_nxt = 1'b0;
                        if (r_bit_cnt >= 4'd10) begin
                            w_state_nxt = w_sda_level ? ST_ERR : ST_RELEASE;
                        end
                    end
                end
            end
            ST_RELEASE: begin
                w_tmo_nxt = r_tmo_cnt + 1'b1;
                w_sda_nxt = 1'b0;
                if (w_scl_level && w_sda_level) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_sda_nxt   = 1'b0;
                w_state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                w_sda_nxt   = 1'b0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_sda_nxt   = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase

        // A silent or stuck device must not hang the host.
        if ((r_state == ST_REQ || r_state == ST_SHIFT || r_state == ST_RELEASE) &&
            (r_tmo_cnt == TMO_LAST)) begin
            w_state_nxt = ST_ERR;
            w_sda_nxt   = 1'b0;
        end
    end

    assign tx_ready = (r_state == ST_IDLE);
    assign busy     = (r_state != ST_IDLE);
    assign scl_low  = (r_state == ST_INHIBIT);
    assign sda_low  = r_sda_low;
    assign done     = (r_state == ST_DONE);
    assign error    = (r_state == ST_ERR);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;
    import ps2_host_tx_pkg::*;

    localparam int INHIBIT = 300;
    localparam int TIMEOUT = 2000;
    localparam int HALF    = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       dev_scl_rel = 1'b1;
    logic       dev_sda_rel = 1'b1;
    logic       tx_ready, scl_low, sda_low, busy, done, error;
    logic       SCL, SDA;

    int n_vec = 0;
    int n_miss = 0;
    int n_done = 0;
    int n_error = 0;
    int s_done0 = 0;
    int s_err0 = 0;

    assign SCL = dev_scl_rel & ~scl_low;
    assign SDA = dev_sda_rel & ~sda_low;

    ps2_host_tx #(.INHIBIT_CYCLES(INHIBIT), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .SCL(SCL), .SDA(SDA), .scl_low(scl_low),
        .sda_low(sda_low), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done)  n_done++;
        if (error) n_error++;
    end

    // Wire order seen by the device at its rising edges: data LSB first, odd parity, stop.
    function automatic logic [9:0] expected_bits(input logic [7:0] d);
        int ones;
        ones = $countones(d);
        return {1'b1, ((ones % 2) == 0), d};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic measure_inhibit(output int n_scl, output int sda_at);
        int c;
        c = 0;
        sda_at = -1;
        while (scl_low && c < INHIBIT + 50) begin
            if (sda_low && sda_at < 0) sda_at = c;
            c++;
            tick();
        end
        n_scl = c;
    endtask

    task automatic dev_clock(input bit ack, input int n_falls, output logic [9:0] bits);
        bits = '0;
        for (int k = 1; k <= n_falls; k++) begin
            if (k == 11) dev_sda_rel = !ack;
            repeat (HALF) tick();
            dev_scl_rel = 1'b0;
            repeat (HALF) tick();
            dev_scl_rel = 1'b1;
            if (k <= 10) bits[k-1] = SDA;
        end
        dev_sda_rel = 1'b1;
    endtask

    task automatic wait_pulse(input int bound, output int cyc);
        cyc = 0;
        while (!done && !error && cyc < bound) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run_frame(input logic [7:0] d, input bit ack, input bit hold, input logic [7:0] next_d,
                             output logic [2:0] post_acc, output int n_scl, output int sda_at,
                             output logic [9:0] bits);
        s_done0 = n_done;
        s_err0  = n_error;
        tx_data = d;
        tx_valid = 1'b1;
        tick();
        if (hold) tx_data = next_d;
        else tx_valid = 1'b0;
        post_acc = {tx_ready, busy, scl_low};
        measure_inhibit(n_scl, sda_at);
        dev_clock(ack, 11, bits);
    endtask

    task automatic finish_frame(output int d_done, output int d_err);
        int cyc;
        wait_pulse(40, cyc);
        tick();
        tick();
        d_done = n_done - s_done0;
        d_err  = n_error - s_err0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        n_vec++; if ({tx_ready, busy, scl_low, sda_low, done, error} !== 6'b100000) begin
            n_miss++; $display("FAIL reset_outputs got=%b want=100000", {tx_ready, busy, scl_low, sda_low, done, error});
        end
    endtask

    task automatic test_send_ed();
        logic [2:0] post; int n_scl, sda_at, dd, de; logic [9:0] bits;
        run_frame(CMD_SET_LEDS, 1'b1, 1'b0, 8'h00, post, n_scl, sda_at, bits);
        n_vec++; if (post !== 3'b011) begin n_miss++; $display("FAIL ed_after_accept ready/busy/scl got=%b want=011", post); end
        n_vec++; if (n_scl !== INHIBIT) begin n_miss++; $display("FAIL ed_inhibit_len got=%0d want=%0d", n_scl, INHIBIT); end
        n_vec++; if (sda_at !== INHIBIT - 1) begin n_miss++; $display("FAIL ed_start_bit_at got=%0d want=%0d", sda_at, INHIBIT - 1); end
        n_vec++; if (bits !== 10'b1_1_11101101) begin n_miss++; $display("FAIL ed_wire_bits got=%b want=%b", bits, 10'b1_1_11101101); end
        finish_frame(dd, de);
        n_vec++; if (dd !== 1 || de !== 0) begin n_miss++; $display("FAIL ed_pulses done=%0d err=%0d want 1/0", dd, de); end
        n_vec++; if (tx_ready !== 1'b1) begin n_miss++; $display("FAIL ed_ready_after got=%b want=1", tx_ready); end
    endtask

    task automatic test_send_f4();
        logic [2:0] post; int n_scl, sda_at, dd, de; logic [9:0] bits;
        run_frame(CMD_ENABLE, 1'b1, 1'b0, 8'h00, post, n_scl, sda_at, bits);
        n_vec++; if (bits[8] !== 1'b0) begin n_miss++; $display("FAIL f4_parity got=%b want=0", bits[8]); end
        n_vec++; if (bits !== expected_bits(CMD_ENABLE)) begin n_miss++; $display("FAIL f4_wire_bits got=%b want=%b", bits, expected_bits(CMD_ENABLE)); end
        finish_frame(dd, de);
        n_vec++; if (dd !== 1 || de !== 0) begin n_miss++; $display("FAIL f4_pulses done=%0d err=%0d want 1/0", dd, de); end
    endtask

    task automatic test_no_ack();
        logic [2:0] post; int n_scl, sda_at, dd, de; logic [9:0] bits;
        run_frame(CMD_RESET, 1'b0, 1'b0, 8'h00, post, n_scl, sda_at, bits);
        n_vec++; if (bits !== expected_bits(CMD_RESET)) begin n_miss++; $display("FAIL ff_wire_bits got=%b want=%b", bits, expected_bits(CMD_RESET)); end
        finish_frame(dd, de);
        n_vec++; if (dd !== 0 || de !== 1) begin n_miss++; $display("FAIL noack_pulses done=%0d err=%0d want 0/1", dd, de); end
        n_vec++; if ({scl_low, sda_low, tx_ready} !== 3'b001) begin
            n_miss++; $display("FAIL noack_released scl/sda/ready got=%b want=001", {scl_low, sda_low, tx_ready});
        end
    endtask

    task automatic test_timeout();
        int n_scl, sda_at, c, e0;
        e0 = n_error;
        tx_data = 8'h5A; tx_valid = 1'b1; tick(); tx_valid = 1'b0;
        measure_inhibit(n_scl, sda_at);
        c = 0;
        while (!error && c < TIMEOUT + 20) begin tick(); c++; end
        n_vec++; if (c !== TIMEOUT) begin n_miss++; $display("FAIL timeout_cycles got=%0d want=%0d", c, TIMEOUT); end
        n_vec++; if ({scl_low, sda_low} !== 2'b00) begin n_miss++; $display("FAIL timeout_released got=%b want=00", {scl_low, sda_low}); end
        tick();
        tick();
        n_vec++; if (tx_ready !== 1'b1 || (n_error - e0) !== 1) begin
            n_miss++; $display("FAIL timeout_after ready=%b errors=%0d want 1/1", tx_ready, n_error - e0);
        end
    endtask

    task automatic test_reset_midframe();
        int n_scl, sda_at, dd, de; logic [9:0] bits; logic [2:0] post;
        tx_data = 8'h01; tx_valid = 1'b1; tick(); tx_valid = 1'b0;
        measure_inhibit(n_scl, sda_at);
        dev_clock(1'b1, 5, bits);
        n_vec++; if (sda_low !== 1'b1) begin n_miss++; $display("FAIL midframe_bit4 sda_low got=%b want=1", sda_low); end
        rst_n = 1'b0;
        tick();
        n_vec++; if ({scl_low, sda_low, tx_ready, busy} !== 4'b0010) begin
            n_miss++; $display("FAIL midframe_reset scl/sda/ready/busy got=%b want=0010", {scl_low, sda_low, tx_ready, busy});
        end
        rst_n = 1'b1;
        tick();
        run_frame(CMD_ENABLE, 1'b1, 1'b0, 8'h00, post, n_scl, sda_at, bits);
        finish_frame(dd, de);
        n_vec++; if (dd !== 1 || de !== 0 || bits !== expected_bits(CMD_ENABLE)) begin
            n_miss++; $display("FAIL after_reset_frame done=%0d err=%0d bits=%b", dd, de, bits);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] post; int n_scl, sda_at, cyc, dd, de; logic [9:0] bits;
        run_frame(CMD_SET_LEDS, 1'b1, 1'b1, 8'hAA, post, n_scl, sda_at, bits);
        n_vec++; if (bits !== expected_bits(CMD_SET_LEDS)) begin n_miss++; $display("FAIL b2b_first_bits got=%b want=%b", bits, expected_bits(CMD_SET_LEDS)); end
        wait_pulse(40, cyc);
        n_vec++; if (done !== 1'b1) begin n_miss++; $display("FAIL b2b_first_done got=%b want=1", done); end
        tick();
        n_vec++; if (tx_ready !== 1'b1) begin n_miss++; $display("FAIL b2b_ready_return got=%b want=1", tx_ready); end
        tick();
        tx_valid = 1'b0;
        n_vec++; if ({tx_ready, busy, scl_low} !== 3'b011) begin
            n_miss++; $display("FAIL b2b_second_accept ready/busy/scl got=%b want=011", {tx_ready, busy, scl_low});
        end
        s_done0 = n_done;
        s_err0  = n_error;
        measure_inhibit(n_scl, sda_at);
        dev_clock(1'b1, 11, bits);
        n_vec++; if (bits !== expected_bits(8'hAA) || bits[8] !== 1'b1) begin
            n_miss++; $display("FAIL b2b_aa_bits got=%b want=%b", bits, expected_bits(8'hAA));
        end
        finish_frame(dd, de);
        n_vec++; if (dd !== 1 || de !== 0) begin n_miss++; $display("FAIL b2b_aa_pulses done=%0d err=%0d want 1/0", dd, de); end
    endtask

    task automatic test_random_frames();
        logic [2:0] post; int n_scl, sda_at, dd, de; logic [9:0] bits; logic [7:0] d; bit ack;
        for (int i = 0; i < 6; i++) begin
            d   = (i == 0) ? RSP_ACK : 8'($urandom);
            ack = ($urandom_range(0, 3) != 0);
            run_frame(d, ack, 1'b0, 8'h00, post, n_scl, sda_at, bits);
            n_vec++; if (n_scl !== INHIBIT) begin n_miss++; $display("FAIL rnd%0d_inhibit got=%0d want=%0d", i, n_scl, INHIBIT); end
            n_vec++; if (bits !== expected_bits(d)) begin n_miss++; $display("FAIL rnd%0d_bits data=%h got=%b want=%b", i, d, bits, expected_bits(d)); end
            finish_frame(dd, de);
            n_vec++; if (dd !== int'(ack) || de !== int'(!ack)) begin
                n_miss++; $display("FAIL rnd%0d_pulses ack=%0d done=%0d err=%0d", i, ack, dd, de);
            end
        end
    endtask

    initial begin
        test_reset();
        test_send_ed();
        test_send_f4();
        test_no_ack();
        test_timeout();
        test_reset_midframe();
        test_back_to_back();
        test_random_frames();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the FPGA to the keyboard on the same SCL/SDA pair that the keyboard-receive path decodes. It runs the inhibit/request-to-send sequence and shifts out start, 8 data bits LSB-first, odd parity and stop on device-generated clock edges. It then checks the device ack. Open-drain behaviour is external: this block only samples the pins and requests a pull-low.

## Interface
- INHIBIT_CYCLES, 5000: clk cycles SCL is held low before the request (100 µs at 50 MHz).
- TIMEOUT_CYCLES, 1000000: max clk cycles from SCL release to ack (20 ms at 50 MHz).
- clk  input  1  system clock.
- rst_n  input  1  synchronous, active-low reset.
- tx_data  input  8  command byte.
- tx_valid  input  1  request; accepted when tx_valid && tx_ready.
- tx_ready  output  1  high only in IDLE.
- SCL  input  1  PS/2 clock pin level (asynchronous).
- SDA  input  1  PS/2 data pin level (asynchronous).
- scl_low  output  1  1 = drive SCL low; 0 = release.
- sda_low  output  1  1 = drive SDA low; 0 = release.
- busy  output  1  high whenever not IDLE; the receive path ignores SCL edges while busy.
- done  output  1  one-cycle pulse: frame acked by device.
- error  output  1  one-cycle pulse: no ack or timeout.

## Operation
- SCL and SDA pass through 2-flop synchronizers. A falling edge is detected when the synchronized SCL goes from previous 1 to current 0.
- Accept: in IDLE, tx_valid && tx_ready latches tx_data and parity = ~^tx_data, clears counters, and enters INHIBIT.
- States and transitions:
  - IDLE: all outputs released, tx_ready=1.
  - INHIBIT: scl_low=1 for INHIBIT_CYCLES cycles. sda_low=1 is asserted on its last cycle. Then go to REQ.
  - REQ: scl_low=0, sda_low=1 (start bit). Timeout counter starts. Go to SHIFT on the first SCL fall.
  - SHIFT: bit_cnt 0..10 advances on each SCL fall:
    - falls 1–8 drive sda_low = ~data[bit_cnt-1];
    - fall 9 drives sda_low = ~parity;
    - fall 10 sets sda_low=0 (stop);
    - fall 11 samples synchronized SDA: 0 = ack, go to RELEASE; 1 = go to ERR.
  - RELEASE: wait until synchronized SCL=1 and SDA=1, then pulse done and go to IDLE.
  - ERR: pulse error, release both lines, go to IDLE.
- Timeout: in REQ, SHIFT or RELEASE, the counter reaching TIMEOUT_CYCLES forces ERR.
- tx_valid while busy is ignored. No queueing; the caller holds tx_valid until it sees tx_ready.
- Widths: the inhibit and timeout counters are sized by $clog2 of their parameters. bit_cnt is 4 bits and saturates at 11.

## Timing
- Reset (rst_n low at a clk edge) sets: state IDLE, scl_low=0, sda_low=0, tx_ready=1, busy=0, done=0, error=0. This holds mid-frame too: the lines are released on the next edge and the device times out on its own.
- tx_ready falls, busy rises and scl_low rises in the cycle after acceptance.
- sda_low asserts INHIBIT_CYCLES-1 cycles after scl_low rises. scl_low falls one cycle later.
- Data update: sda_low changes exactly 1 clk after the falling edge is detected. That is 3 clk after the pin edge, well inside the ≥5 µs SCL-low half period.
- done and error are registered, 1 cycle wide, and mutually exclusive. tx_ready returns the cycle after the pulse.
- A new tx_valid may be accepted in the cycle tx_ready is high again. No minimum gap is required.

## Structure
- Shared package constants: PS2 command codes (CMD_SET_LEDS=8'hED, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF, RSP_ACK=8'hFA) and the FSM state encoding.
- One sub-module, ps2_sync_edge: a 2-flop synchronizer plus falling-edge detect. The existing receive path should reuse it.

## Test plan
- Send 0xED with a device model ack:
  - SCL held low 5000 cycles, then the start bit is driven.
  - Bits observed at rising SCL are 1,0,1,1,0,1,1,1, then parity 1, then stop 1.
  - Device pulls SDA low at clock 11; expect one done pulse and no error.
- Send 0xF4: observed parity bit 0; done pulse.
- Send 0xFF with no device ack (SDA high at clock 11): expect one error pulse, both lines released, tx_ready=1.
- Device never clocks after the request: expect error exactly TIMEOUT_CYCLES cycles after scl_low falls, and sda_low=0.
- rst_n low after clock 5 of a 0x01 frame: both drives released next cycle. A subsequent 0xF4 frame completes with done.
- tx_valid held high with 0xAA during a 0xED frame: ignored. 0xAA is accepted in the cycle tx_ready returns and transmits with parity 1.
